// File: rtl/drum_div_pkg.sv
// Shared types and sizing helpers for the DRUM-style approximate divider.
package drum_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } state_e;

  localparam int K_DEF = 6;
  localparam int KA    = 2 * K_DEF;

  // Dividend window is twice the divisor window.
  function automatic int ka_of(input int k);
    return 2 * k;
  endfunction

  // Shift-amount width; one extra bit so the signed difference p - q fits.
  function automatic int shift_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/drum_div_seq_if.sv
// Valid/ready operand and result streams of the approximate divider.
interface drum_div_seq_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic             out_dz;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_q, out_dz
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_q, out_dz
  );

endinterface

// File: rtl/drum_div_norm.sv
// Leading-one anchored operand window: extracts WIN bits below the leading one,
// forces the window LSB when bits were dropped, and reports the drop count.
module drum_div_norm #(
  parameter int WIDTH = 16,
  parameter int WIN   = 6,
  parameter int SHW   = 5
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIN-1:0]   m_o,
  output logic [SHW-1:0]   sh_o
);

  int               lead;
  int               sh;
  logic [WIDTH-1:0] shifted;

  // NOTE: every variable written here gets a value before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    lead = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x_i[i]) lead = i;
    end

    // Operands that already fit the window (including zero) pass unchanged.
    if (lead < WIN) sh = 0;
    else            sh = lead - WIN + 1;

    shifted = x_i >> sh;
    m_o     = shifted[WIN-1:0];
    if (sh != 0) m_o[0] = 1'b1;
    sh_o    = SHW'(sh);
  end

endmodule

// File: rtl/drum_div_seq.sv
// Sequential DRUM-style approximate unsigned divider behind valid/ready streams.
// Define DRUM_DIV_RADIX4_EN to retire two quotient bits per DIV cycle.
module drum_div_seq
  import drum_div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = K_DEF
) (
  input logic           clk,
  input logic           rst_n,
  drum_div_seq_if.slave bus
);

  localparam int KA_W = ka_of(K);
  localparam int SHW  = shift_w(WIDTH);
  localparam int VW   = K + KA_W;
`ifdef DRUM_DIV_RADIX4_EN
  localparam int ITER = KA_W / 2;
`else
  localparam int ITER = KA_W;
`endif
  localparam int             CNT_W    = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [KA_W-1:0]   quot_q, quot_d;
  logic [K-1:0]      rem_q, rem_d;
  logic [K-1:0]      mb_q, mb_d;
  logic [SHW-1:0]    psh_q, psh_d;
  logic [SHW-1:0]    qsh_q, qsh_d;
  logic              dz_q, dz_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              res_dz_q, res_dz_d;

  logic [KA_W-1:0]   ma;
  logic [K-1:0]      mb;
  logic [SHW-1:0]    pa;
  logic [SHW-1:0]    qb;

  drum_div_norm #(.WIDTH(WIDTH), .WIN(KA_W), .SHW(SHW)) u_norm_a (
    .x_i (bus.in_a),
    .m_o (ma),
    .sh_o(pa)
  );

  drum_div_norm #(.WIDTH(WIDTH), .WIN(K), .SHW(SHW)) u_norm_b (
    .x_i (bus.in_b),
    .m_o (mb),
    .sh_o(qb)
  );

  // One restoring step on {remainder, dividend/quotient}: the dividend MSB
  // moves into the remainder and the new quotient bit enters at the LSB.
  function automatic logic [VW-1:0] div_step(input logic [VW-1:0] v,
                                             input logic [K-1:0]  d);
    logic [K:0]   rs;
    logic [K:0]   diff;
    logic [K-1:0] r;
    logic         bit_q;
    rs    = {v[VW-1:KA_W], v[KA_W-1]};
    diff  = rs - {1'b0, d};
    bit_q = (rs >= {1'b0, d});
    r     = bit_q ? diff[K-1:0] : rs[K-1:0];
    return {r, v[KA_W-2:0], bit_q};
  endfunction

  logic signed [SHW-1:0]   s;
  logic signed [SHW-1:0]   neg_s;
  logic [2*WIDTH-1:0]      quot_ext;
  logic [2*WIDTH-1:0]      wide;
  logic [WIDTH-1:0]        norm_val;
  logic [VW-1:0]           step_v;

  always_comb begin
    s        = $signed(psh_q) - $signed(qsh_q);
    neg_s    = -s;
    quot_ext = (2*WIDTH)'(quot_q);
    wide     = s[SHW-1] ? (quot_ext >> $unsigned(neg_s)) : (quot_ext << $unsigned(s));
    // Any bit pushed past the top of the result saturates it.
    norm_val = (|wide[2*WIDTH-1:WIDTH]) ? '1 : wide[WIDTH-1:0];
  end

  always_comb begin
`ifdef DRUM_DIV_RADIX4_EN
    step_v = div_step(div_step({rem_q, quot_q}, mb_q), mb_q);
`else
    step_v = div_step({rem_q, quot_q}, mb_q);
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    mb_d     = mb_q;
    psh_d    = psh_q;
    qsh_d    = qsh_q;
    dz_d     = dz_q;
    res_d    = res_q;
    res_dz_d = res_dz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          quot_d  = ma;
          rem_d   = '0;
          mb_d    = mb;
          psh_d   = pa;
          qsh_d   = qb;
          dz_d    = (bus.in_b == '0);
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        // The final DIV cycle only settles the quotient; latency stays fixed.
        if (cnt_q == CNT_LAST) begin
          state_d = NORM;
        end else begin
          {rem_d, quot_d} = step_v;
          cnt_d           = cnt_q + CNT_W'(1);
        end
      end
      NORM: begin
        res_d    = dz_q ? '1 : norm_val;
        res_dz_d = dz_q;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers update with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      mb_q     <= '0;
      psh_q    <= '0;
      qsh_q    <= '0;
      dz_q     <= 1'b0;
      res_q    <= '0;
      res_dz_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      mb_q     <= mb_d;
      psh_q    <= psh_d;
      qsh_q    <= qsh_d;
      dz_q     <= dz_d;
      res_q    <= res_d;
      res_dz_q <= res_dz_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_q     = res_q;
  assign bus.out_dz    = res_dz_q;

endmodule

// File: doc/drum_div_seq.md
Name: drum_div_seq

Overview:
- Sequential approximate unsigned divider using dynamic-range truncation (DRUM-style), the inverse operation of the team's DRUM multipliers.
- Each operand is cut to a small window anchored at its leading one; the window LSB is forced to 1 for unbiased error.
- A small iterative restoring divider divides the windows; the quotient is then shifted by the difference of the truncation amounts.
- Sits in approximate-arithmetic datapaths behind a valid/ready stream interface.

Parameters:
- WIDTH, 16, operand and quotient width.
- K, 6, divisor window width; dividend window KA = 2*K (must satisfy KA <= WIDTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  dividend.
- in_b  in  WIDTH  divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_q  out  WIDTH  approximate quotient.
- out_dz  out  1  divide-by-zero flag, qualified by out_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: in_ready=1, out_valid=0, out_q=0, out_dz=0, FSM=IDLE.
- Reset asserted mid-operation aborts immediately and returns to reset values; no partial result is emitted.
- FSM states: IDLE -> DIV -> NORM -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid&&in_ready at edge T.
  - Latch ma, mb, p, q, zero flag; go to DIV.
- Dividend window:
  - If in_a < 2^KA: p=0, ma=in_a.
  - Otherwise, with L = leading-one index: p = L-KA+1, ma = {in_a[L:p+1], 1'b1}.
- Divisor window: same rule with window K, shift q, result mb.
- DIV: restoring division of ma by mb, one quotient bit per cycle, KA cycles (T+1..T+KA); partial remainder is K+1 bits.
- NORM (cycle T+KA+1), with s = p - q as a signed value:
  - s >= 0: out_q = quot << s.
  - s < 0: out_q = quot >> -s (truncating).
  - Saturate to 2^WIDTH-1 if any bit is shifted out on the left.
- DONE:
  - out_valid=1 from edge T+KA+2; in_ready=0.
  - out_q and out_dz are held stable until out_valid&&out_ready, then return to IDLE.
- Latency is fixed at KA+2 cycles, independent of operand values, including divide by zero.
- Back-to-back: after the output handshake at edge U, in_ready=1 from U; the next accept is at U+1 at the earliest. No overlap.
- Divide by zero (in_b=0): out_q = all ones, out_dz=1. The DIV cycles still run, but their result is ignored.
- in_a=0 with in_b!=0: out_q=0, out_dz=0.
- in_a and in_b are don't-care outside the accept cycle.

Optional Feature:
- Macro: DRUM_DIV_RADIX4_EN.
- Defined:
  - DIV retires 2 quotient bits per cycle over KA/2 cycles; latency KA/2+2 (8 for defaults).
  - K must be such that KA is even (always true since KA=2*K).
- Undefined: radix-2 as above, latency KA+2 (14 for defaults).
- Numerical results are bit-identical in both builds.

Decomposition:
- Package drum_div_pkg:
  - state enum {IDLE, DIV, NORM, DONE};
  - localparam KA;
  - width function for the shift counters (clog2(WIDTH)+1, signed for s).
- Sub-module drum_div_norm, instantiated once per operand:
  - combinational leading-one detect, window extract, forced LSB, shift amount;
  - parameterised by window width.
- Iteration and shift logic stay in the top module.

Test Plan:
- a=1000, b=10 (no truncation) -> out_q=100, out_dz=0, out_valid exactly 14 cycles after accept (8 with DRUM_DIV_RADIX4_EN).
- a=60000, b=300:
  - p=4, ma=3751; q=3, mb=37;
  - quot=101, s=1 -> out_q=202, out_dz=0.
- a=5, b=0 -> out_q=16'hFFFF, out_dz=1, same fixed latency.
- a=16'hFFFF, b=1 -> ma=4095, p=4, quot=4095 -> out_q=16'hFFF0, no saturation.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_q/out_dz stable, in_ready=0, a second in_valid is ignored; the release completes the handshake and the next operands are accepted the following cycle.
- Assert rst_n low during DIV cycle 5 -> out_valid=0, in_ready=1 immediately; a new operation after reset yields the correct result.
